fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the pipeline front end. Owns the architectural PC register and computes next-PC for branch, jump and jump-register redirects. Drives a multi-cycle instruction-memory request/ready handshake and feeds a single-entry IF output register to the IF/ID stage. Handles back-pressure from the hazard unit, and drains an in-flight fetch cleanly when a redirect arrives mid-request.

---
 rtl/fetch_ctrl_if.sv | 21 ++
 rtl/fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory handshake and IF output register bundle for fetch_ctrl.
// master = fetch sequencer side, slave = memory / IF-ID consumer side.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_ready, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_ready, imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC register, redirect target calculation, imem request/ready
// handshake with redirect drain, single-entry IF output register.
// Optional FETCH_ALIGN_CHECK_EN: adds align_fault and word-aligns redirect targets.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [1:0]  redir_kind,
    input  logic [31:0] redir_pc,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_addr,
    input  logic [31:0] jr_target,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        align_fault,
`endif
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pend, pend_n;
    logic        outst, outst_n;
    logic        ifv_q, ifv_n;
    logic [31:0] ifpc_q, ifpc_n;
    logic [31:0] ifin_q, ifin_n;
    logic [31:0] tgt_raw, tgt;
    logic        free, req, done;

    always_comb begin
        tgt_raw = redir_pc + 32'd4;
        case (redir_kind)
            2'b00:   tgt_raw = {redir_pc[31:2] + {{14{br_imm[15]}}, br_imm}, 2'b00};
            2'b01:   tgt_raw = {redir_pc[31:28], j_addr, 2'b00};
            2'b10:   tgt_raw = jr_target;
            default: tgt_raw = redir_pc + 32'd4;
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt = {tgt_raw[31:2], 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            align_fault <= 1'b0;
        end else begin
            align_fault <= redir_valid && (tgt_raw[1:0] != 2'b00);
        end
    end
`else
    assign tgt = tgt_raw;
`endif

    assign free = !ifv_q || !stall;
    assign done = req && bus.imem_ready;

    // pc stays at the in-flight address during DRAIN, so imem_addr is simply pc.
    assign bus.imem_req  = req;
    assign bus.imem_addr = pc;
    assign bus.if_valid  = ifv_q;
    assign bus.if_pc     = ifpc_q;
    assign bus.if_instr  = ifin_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= BOOT;
            pc     <= RESET_PC;
            pend   <= '0;
            outst  <= 1'b0;
            ifv_q  <= 1'b0;
            ifpc_q <= RESET_PC;
            ifin_q <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            pend   <= pend_n;
            outst  <= outst_n;
            ifv_q  <= ifv_n;
            ifpc_q <= ifpc_n;
            ifin_q <= ifin_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        pend_n  = pend;
        outst_n = outst;
        ifv_n   = ifv_q;
        ifpc_n  = ifpc_q;
        ifin_n  = ifin_q;
        req     = 1'b0;

        case (state)
            BOOT: begin
                state_n = FETCH;
                outst_n = 1'b0;
                if (redir_valid) begin
                    pc_n = tgt;
                end
            end

            FETCH: begin
                // An outstanding request is never withdrawn, even under stall.
                req = free || outst;
                if (redir_valid) begin
                    ifv_n   = 1'b0;
                    outst_n = 1'b0;
                    if (req && !bus.imem_ready) begin
                        pend_n  = tgt;
                        state_n = DRAIN;
                    end else begin
                        pc_n = tgt;
                    end
                end else if (done) begin
                    pc_n    = pc + 32'd4;
                    ifv_n   = 1'b1;
                    ifpc_n  = pc;
                    ifin_n  = bus.imem_rdata;
                    outst_n = 1'b0;
                end else begin
                    outst_n = req;
                    if (ifv_q && !stall) begin
                        ifv_n = 1'b0;
                    end
                end
            end

            DRAIN: begin
                req = 1'b1;
                if (redir_valid) begin
                    pend_n = tgt;
                    ifv_n  = 1'b0;
                end
                if (bus.imem_ready) begin
                    pc_n    = redir_valid ? tgt : pend;
                    state_n = FETCH;
                    outst_n = 1'b0;
                end
            end

            default: begin
                state_n = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl: the driver queues the expected next
// delivered PC on every redirect; a negedge monitor checks deliveries and handshake rules.
module tb_fetch_ctrl;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redir_valid = 1'b0;
    logic [1:0]  redir_kind = 2'b00;
    logic [31:0] redir_pc = '0;
    logic [15:0] br_imm = '0;
    logic [25:0] j_addr = '0;
    logic [31:0] jr_target = '0;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redir_valid(redir_valid),
        .redir_kind (redir_kind),
        .redir_pc   (redir_pc),
        .br_imm     (br_imm),
        .j_addr     (j_addr),
        .jr_target  (jr_target),
`ifdef FETCH_ALIGN_CHECK_EN
        .align_fault(align_fault),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned n_deliv = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_pc = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign bus.imem_rdata = memf(bus.imem_addr);

    // Reference target: plain address arithmetic on the redirect fields.
    function automatic logic [31:0] model_target(input logic [1:0] k, input logic [31:0] rpc,
                                                 input logic [15:0] imm, input logic [25:0] ja,
                                                 input logic [31:0] jt);
        logic [31:0] simm;
        simm = {{16{imm[15]}}, imm};
        case (k)
            2'd0:    return (rpc & 32'hFFFF_FFFC) + (simm * 32'd4);
            2'd1:    return (rpc & 32'hF000_0000) + ({6'b0, ja} * 32'd4);
            2'd2:    return jt;
            default: return rpc + 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        return t & 32'hFFFF_FFFC;
`else
        return t;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue_redirect(input logic [1:0] k, input logic [31:0] rpc, input logic [15:0] imm,
                                  input logic [25:0] ja, input logic [31:0] jt);
        redir_valid = 1'b1;
        redir_kind  = k;
        redir_pc    = rpc;
        br_imm      = imm;
        j_addr      = ja;
        jr_target   = jt;
        exp_q.delete();
        exp_q.push_back(eff_target(model_target(k, rpc, imm, ja, jt)));
    endtask

    // Monitor
    logic        prev_wait = 1'b0, prev_hold = 1'b0, prev_mis = 1'b0;
    logic [31:0] prev_addr = '0, prev_pc = '0, prev_instr = '0;
    logic [31:0] exp_pc, raw_t;

    always @(negedge clk) begin
        if (!reset) begin
            prev_wait = 1'b0;
            prev_hold = 1'b0;
            prev_mis  = 1'b0;
        end else begin
            if (prev_wait) begin
                check("req_held", {31'b0, bus.imem_req}, 32'd1);
                check("addr_stable", bus.imem_addr, prev_addr);
            end
            if (prev_hold) begin
                check("hold_valid", {31'b0, bus.if_valid}, 32'd1);
                check("hold_pc", bus.if_pc, prev_pc);
                check("hold_instr", bus.if_instr, prev_instr);
            end
`ifdef FETCH_ALIGN_CHECK_EN
            check("align_fault", {31'b0, align_fault}, {31'b0, prev_mis});
`endif
            if (bus.if_valid && !stall && !redir_valid) begin
                if (exp_q.size() != 0) exp_pc = exp_q.pop_front();
                else                   exp_pc = last_pc + 32'd4;
                check("deliver_pc", bus.if_pc, exp_pc);
                check("deliver_instr", bus.if_instr, memf(bus.if_pc));
                last_pc = bus.if_pc;
                n_deliv++;
            end
            prev_wait  = bus.imem_req && !bus.imem_ready;
            prev_addr  = bus.imem_addr;
            prev_hold  = bus.if_valid && stall && !redir_valid;
            prev_pc    = bus.if_pc;
            prev_instr = bus.if_instr;
            raw_t      = model_target(redir_kind, redir_pc, br_imm, j_addr, jr_target);
            prev_mis   = redir_valid && (raw_t[1:0] != 2'b00);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] a_hold;
    logic        seen;
    int unsigned deliv_before;

    initial begin
        bus.imem_ready = 1'b1;
        exp_q.push_back(RPC);
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, bus.imem_req}, 32'd0);
        check("rst_addr", bus.imem_addr, RPC);
        check("rst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_if_pc", bus.if_pc, RPC);
        check("rst_if_instr", bus.if_instr, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_align", {31'b0, align_fault}, 32'd0);
`endif

        // Release: BOOT cycle, then one fetch per cycle.
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        check("boot_req", {31'b0, bus.imem_req}, 32'd0);
        @(negedge clk);
        check("f0_req", {31'b0, bus.imem_req}, 32'd1);
        check("f0_addr", bus.imem_addr, 32'h3000);
        check("f0_valid", {31'b0, bus.if_valid}, 32'd0);
        @(negedge clk);
        check("f1_addr", bus.imem_addr, 32'h3004);
        check("f1_valid", {31'b0, bus.if_valid}, 32'd1);
        check("f1_if_pc", bus.if_pc, 32'h3000);
        @(negedge clk);
        check("f2_addr", bus.imem_addr, 32'h3008);

        // Stall holds the output register and blocks new requests.
        @(posedge clk); #1; stall = 1'b1;
        @(negedge clk);
        a_hold = bus.imem_addr;
        check("stall_if_pc", bus.if_pc, 32'h3008);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_addr", bus.imem_addr, a_hold);
            check("stall_req", {31'b0, bus.imem_req}, 32'd0);
            check("stall_if_pc_hold", bus.if_pc, 32'h3008);
        end
        @(posedge clk); #1; stall = 1'b0;

        // Redirects hit a waiting request: drain, latest target wins.
        @(posedge clk); #1; bus.imem_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.imem_req) seen = 1'b1;
        end
        check("drain_req_up", {31'b0, seen}, 32'd1);
        a_hold = bus.imem_addr;
        @(posedge clk); #1; issue_redirect(2'd2, 32'h0, 16'h0, 26'h0, 32'h4000);
        @(negedge clk); check("drain_addr0", bus.imem_addr, a_hold);
        @(posedge clk); #1; redir_valid = 1'b0;
        @(negedge clk); check("drain_addr1", bus.imem_addr, a_hold);
        @(posedge clk); #1; issue_redirect(2'd2, 32'h0, 16'h0, 26'h0, 32'h5000);
        @(negedge clk); check("drain_addr2", bus.imem_addr, a_hold);
        @(posedge clk); #1; redir_valid = 1'b0; bus.imem_ready = 1'b1;
        @(negedge clk);
        check("drain_req_last", {31'b0, bus.imem_req}, 32'd1);
        check("drain_addr3", bus.imem_addr, a_hold);
        @(negedge clk);
        check("drain_new_addr", bus.imem_addr, 32'h5000);

        // Jump through the top of the address space.
        @(posedge clk); #1; issue_redirect(2'd2, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFF8);
        @(posedge clk); #1; redir_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.if_valid && bus.if_pc == 32'h0) seen = 1'b1;
        end
        check("wrap_to_zero", {31'b0, seen}, 32'd1);

        // Unaligned register target.
        @(posedge clk); #1; issue_redirect(2'd2, 32'h0, 16'h0, 26'h0, 32'h4002);
        @(posedge clk); #1; redir_valid = 1'b0;
        @(negedge clk);
        check("unaligned_addr", bus.imem_addr, eff_target(32'h4002));
`ifdef FETCH_ALIGN_CHECK_EN
        check("align_pulse", {31'b0, align_fault}, 32'd1);
        @(negedge clk);
        check("align_clear", {31'b0, align_fault}, 32'd0);
`endif

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            redir_valid    = 1'b0;
            stall          = ($urandom_range(0, 3) == 0);
            bus.imem_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) begin
                issue_redirect(2'($urandom_range(0, 3)), $urandom, 16'($urandom),
                               26'($urandom), $urandom);
            end
        end
        @(posedge clk); #1; redir_valid = 1'b0; stall = 1'b0; bus.imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("progress", {31'b0, (n_deliv >= 300) ? 1'b1 : 1'b0}, 32'd1);

        // Reset in the middle of a drain drops the request at once.
        @(posedge clk); #1; bus.imem_ready = 1'b0;
        @(posedge clk); #1; issue_redirect(2'd3, 32'h0000_7000, 16'h0, 26'h0, 32'h0);
        @(posedge clk); #1; redir_valid = 1'b0;
        @(negedge clk); check("mid_drain_req", {31'b0, bus.imem_req}, 32'd1);
        @(posedge clk); #1; reset = 1'b0;
        #1;
        check("reset_drops_req", {31'b0, bus.imem_req}, 32'd0);
        check("reset_addr", bus.imem_addr, RPC);
        exp_q.delete();
        exp_q.push_back(RPC);
        deliv_before = n_deliv;
        @(posedge clk); #1; reset = 1'b1; bus.imem_ready = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("restart_deliveries", {31'b0, (n_deliv >= deliv_before + 5) ? 1'b1 : 1'b0}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
